serial_adder_nbit: RTL and testbench
====================================

// Module: serial_adder_nbit
// PURPOSE
//  Multi-cycle, area-reduced successor to the combinational n-bit adder: adds NUM_BITS operands
//  CHUNK_BITS per clock through one shared chunk adder with a registered carry. Start/busy/done
//  handshake; registered result held until the next completed add. Used where wide adds need not
//  finish in one cycle and ripple depth must stay at CHUNK_BITS.
// PARAMETERS
//  NUM_BITS    16  operand/sum width; must be a multiple of CHUNK_BITS (else $fatal at elaboration)
//  CHUNK_BITS  4   bits added per clock; NUM_CHUNKS = NUM_BITS/CHUNK_BITS (localparam)
// PORTS
//  clk       in   1         system clock, rising edge
//  n_rst     in   1         asynchronous active-low reset
//  start     in   1         request add; sampled only in IDLE or DONE
//  a         in   NUM_BITS  operand A, sampled on accepted start
//  b         in   NUM_BITS  operand B, sampled on accepted start
//  carry_in  in   1         carry into bit 0, sampled on accepted start
//  busy      out  1         high while in ADD
//  done      out  1         one-cycle pulse: sum/overflow just updated
//  sum       out  NUM_BITS  registered result of last completed add
//  overflow  out  1         registered carry out of bit NUM_BITS-1 of last completed add
// BEHAVIOUR
//  - One clock; reset asynchronous active-low. Reset: state IDLE, busy=0, done=0, sum=0,
//    overflow=0, chunk index=0, working regs=0. Reset mid-add aborts; no done ever issued for it.
//  - FSM IDLE/ADD/DONE. IDLE: start=1 -> latch a,b,carry_in into working regs, idx=0, -> ADD.
//  - ADD: each edge adds chunk idx of A,B plus carry reg; writes result slice and new carry; idx++.
//    On edge processing idx=NUM_CHUNKS-1: sum<=full working result, overflow<=final carry, -> DONE.
//  - Latency: start sampled at edge E0; done high in cycle after edge E_NUM_CHUNKS (4 clk at default).
//  - busy=1 exactly in ADD. start while busy ignored; operands/carry_in may change freely then.
//  - DONE (1 cycle, done=1): start=1 -> accept new operation as in IDLE (back-to-back, no bubble),
//    else -> IDLE. done never held over 1 cycle.
//  - sum/overflow change only on the completing edge (or reset); stable during next add.
//  - Arithmetic unsigned: {overflow,sum} == a + b + carry_in, NUM_BITS+1 bits, wraps modulo 2^NUM_BITS.
//  - Chunk carry exits at bit CHUNK_BITS of chunk sum; idx wraps to 0 on completion.
// CONFIGURATION
//  SERIAL_ADDER_SAT_EN defined: on completion with final carry=1, sum<=all ones (unsigned saturate);
//    overflow still 1. Undefined: sum wraps (low NUM_BITS of true sum). No other behaviour differs.
// STRUCTURE
//  - Package serial_adder_pkg: typedef enum logic [1:0] {IDLE, ADD, DONE} adder_state_t;
//    default width constants (DEF_NUM_BITS=16, DEF_CHUNK_BITS=4).
//  - One sub-module: existing adder_nbit #(CHUNK_BITS) as the per-cycle chunk adder
//    (a/b slice, carry_in=carry reg, overflow -> next carry). Index/FSM/registers in top.
// TESTING  (NUM_BITS=16, CHUNK_BITS=4)
//  1 Reset asserted, then released -> busy=0, done=0, sum=16'h0000, overflow=0; async (no clk needed).
//  2 a=16'h1234,b=16'h4321,cin=0, 1-cycle start -> busy 4 cycles, done 4 clk after start edge,
//    sum=16'h5555, overflow=0.
//  3 a=16'hFFFF,b=16'h0000,cin=1 -> sum=16'h0000, overflow=1 (SAT_EN: sum=16'hFFFF, overflow=1);
//    verifies carry ripple across all chunks.
//  4 start a=16'h00F0,b=16'h0010; during busy pulse start with a=16'hAAAA -> ignored; sum=16'h0100,
//    exactly one done pulse.
//  5 n_rst low during 2nd ADD cycle -> all outputs 0 immediately, no done; next add correct.
//  6 start held high across done -> back-to-back ops, done every 5 cycles; plus 512 random
//    vectors checked against {overflow,sum}==a+b+cin; final block reports completion count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the serial (chunked) n-bit adder.
//   adder_state_t   : IDLE / ADD / DONE controller states
//   DEF_NUM_BITS    : default operand/sum width
//   DEF_CHUNK_BITS  : default number of bits added per clock
//   chunk_count()   : number of chunks needed for a given width/chunk size
// ----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  localparam int DEF_NUM_BITS   = 16;
  localparam int DEF_CHUNK_BITS = 4;

  function automatic int chunk_count(input int num_bits, input int chunk_bits);
    return num_bits / chunk_bits;
  endfunction

endpackage

// File: rtl/serial_adder_nbit_if.sv
// ----------------------------------------------------------------------------
// serial_adder_nbit_if
// Start/busy/done handshake and operand/result bus of the serial adder.
//   start, a, b, carry_in : driven by the requester (master)
//   busy, done, sum, overflow : driven by the adder (slave)
// Parameter NUM_BITS must match the adder's NUM_BITS.
// ----------------------------------------------------------------------------
interface serial_adder_nbit_if #(
  parameter int NUM_BITS = 16
) ();

  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );

endinterface

// File: rtl/serial_adder_nbit_chunk.sv
// ----------------------------------------------------------------------------
// adder_nbit
// Combinational ripple-carry adder used as the per-clock chunk adder of the
// serial adder. {overflow, sum} = a + b + carry_in.
//   a, b      in  NUM_BITS  operands
//   carry_in  in  1         carry into bit 0
//   sum       out NUM_BITS  low NUM_BITS of the result
//   overflow  out 1         carry out of bit NUM_BITS-1
// ----------------------------------------------------------------------------
module adder_nbit #(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  // Ripple carry held in a procedural variable so the chain stays a single
  // combinational process rather than a self-referencing vector.
  logic carry_v;

  always_comb begin
    carry_v = carry_in;
    sum     = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
    end
    overflow = carry_v;
  end

endmodule

// File: rtl/serial_adder_nbit.sv
// ----------------------------------------------------------------------------
// serial_adder_nbit
// Multi-cycle adder: adds two NUM_BITS operands CHUNK_BITS per clock through
// one shared chunk adder (adder_nbit) with a registered carry. A start request
// accepted in IDLE or DONE latches the operands; NUM_CHUNKS clocks later the
// registered sum/overflow update and done pulses for one cycle.
//   clk       in   1         clock, rising edge
//   n_rst     in   1         asynchronous active-low reset
//   bus       slave modport of serial_adder_nbit_if:
//               start, a, b, carry_in (in) / busy, done, sum, overflow (out)
// Optional feature macro: SERIAL_ADDER_SAT_EN -- when defined, a completed
// add with a final carry of 1 saturates sum to all ones (overflow still 1).
// ----------------------------------------------------------------------------
module serial_adder_nbit
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS   = DEF_NUM_BITS,
  parameter int CHUNK_BITS = DEF_CHUNK_BITS
) (
  input  logic               clk,
  input  logic               n_rst,
  serial_adder_nbit_if.slave bus
);

  localparam int NUM_CHUNKS = chunk_count(NUM_BITS, CHUNK_BITS);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Reject configurations the chunked datapath cannot represent.
  generate
    if ((CHUNK_BITS < 1) || (NUM_BITS % CHUNK_BITS != 0)) begin : g_bad_cfg
      $fatal(1, "serial_adder_nbit: NUM_BITS must be a multiple of CHUNK_BITS");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  adder_state_t        state_q,    state_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [NUM_BITS-1:0] a_q,        a_d;        // working operand A
  logic [NUM_BITS-1:0] b_q,        b_d;        // working operand B
  logic [NUM_BITS-1:0] res_q,      res_d;      // partial result, filled chunk by chunk
  logic                carry_q,    carry_d;    // carry between chunks
  logic [NUM_BITS-1:0] sum_q,      sum_d;      // published result
  logic                overflow_q, overflow_d; // published carry out

  // --------------------------------------------------------------------------
  // Chunk selection: split working operands into CHUNK_BITS slices and pick
  // the one addressed by the chunk index.
  // --------------------------------------------------------------------------
  logic [CHUNK_BITS-1:0] a_chunk [NUM_CHUNKS];
  logic [CHUNK_BITS-1:0] b_chunk [NUM_CHUNKS];

  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      assign a_chunk[gi] = a_q[gi*CHUNK_BITS +: CHUNK_BITS];
      assign b_chunk[gi] = b_q[gi*CHUNK_BITS +: CHUNK_BITS];
    end
  endgenerate

  logic [CHUNK_BITS-1:0] chunk_a;
  logic [CHUNK_BITS-1:0] chunk_b;
  logic [CHUNK_BITS-1:0] chunk_sum;
  logic                  chunk_cout;

  assign chunk_a = a_chunk[idx_q];
  assign chunk_b = b_chunk[idx_q];

  adder_nbit #(
    .NUM_BITS (CHUNK_BITS)
  ) u_chunk_adder (
    .a        (chunk_a),
    .b        (chunk_b),
    .carry_in (carry_q),
    .sum      (chunk_sum),
    .overflow (chunk_cout)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request just like IDLE so back-to-back adds
        // lose no cycle; without a request both return to IDLE.
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.carry_in;
          res_d   = '0;
          idx_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            res_d[i*CHUNK_BITS +: CHUNK_BITS] = chunk_sum;
          end
        end
        carry_d = chunk_cout;

        if (idx_q == LAST_IDX) begin
          // res_d already includes the final chunk written above.
          sum_d      = res_d;
          overflow_d = chunk_cout;
`ifdef SERIAL_ADDER_SAT_EN
          if (chunk_cout) begin
            sum_d = '1;
          end
`else
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded directly from registers
  // --------------------------------------------------------------------------
  assign bus.busy     = (state_q == ADD);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_nbit
// Directed and random stimulus for serial_adder_nbit (NUM_BITS=16,
// CHUNK_BITS=4). Expected results are queued when an add is issued; a
// separate monitor pops one entry on every done pulse and compares it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_adder_nbit;

  localparam int NB = 16;
  localparam int CB = 4;
  localparam int NUM_RANDOM = 512;
  localparam int NUM_DIRECTED_B2B = 4;
  localparam int NUM_B2B = NUM_DIRECTED_B2B + NUM_RANDOM;

  logic clk;
  logic n_rst;

  serial_adder_nbit_if #(.NUM_BITS(NB)) bus ();

  serial_adder_nbit #(
    .NUM_BITS   (NB),
    .CHUNK_BITS (CB)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int completions = 0;
  int pushes = 0;
  logic [NB:0] exp_q [$];
  logic [NB-1:0] last_sum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end else begin
      $display("ok   %s value=0x%0h t=%0t", name, act, $time);
    end
  endtask

  function automatic logic [NB:0] sat_adj(input logic [NB:0] t);
    logic [NB:0] r;
    r = t;
`ifdef SERIAL_ADDER_SAT_EN
    if (r[NB]) r[NB-1:0] = '1;
`endif
    return r;
  endfunction

  function automatic logic [NB:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                        input logic cin);
    logic [NB:0] t;
    t = {1'b0, a} + {1'b0, b} + {{NB{1'b0}}, cin};
    return sat_adj(t);
  endfunction

  task automatic push_exp(input logic [NB:0] e);
    exp_q.push_back(e);
    pushes++;
    last_sum = e[NB-1:0];
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one comparison per done pulse
  // --------------------------------------------------------------------------
  initial begin
    logic prev_done;
    logic [NB:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst && bus.done) begin
        completions++;
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width actual=2_cycles required=1_cycle t=%0t", $time);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=sum 0x%0h ov %0b required=no_done t=%0t",
                   bus.sum, bus.overflow, $time);
        end else begin
          e = exp_q.pop_front();
          check("result{ov,sum}", {15'd0, bus.overflow, bus.sum}, {15'd0, e});
        end
      end
      prev_done = bus.done;
    end
  end

  // --------------------------------------------------------------------------
  // Single operation with latency / busy / stability checks.
  // When interfere is set, a second start with different operands is pulsed
  // while the first add is busy; it must be ignored.
  // --------------------------------------------------------------------------
  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic cin,
                       input logic [NB:0] exp_res, input bit interfere);
    int k;
    int busy_cnt;
    logic [NB-1:0] held_sum;
    held_sum = last_sum;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.carry_in = cin; bus.start = 1'b1;
    @(posedge clk);
    push_exp(exp_res);
    #1;
    bus.start = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.carry_in = ~cin;  // operands may change while busy
    k = 0;
    busy_cnt = 0;
    while (!bus.done && k < 20) begin
      if (bus.busy) busy_cnt++;
      if (k == 2) check("sum_stable_during_add", {16'd0, bus.sum}, {16'd0, held_sum});
      if (interfere && k == 1) begin
        bus.start = 1'b1; bus.a = 16'hAAAA;
      end
      if (interfere && k == 2) bus.start = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    bus.start = 1'b0;
    check("done_latency", k, 4);
    check("busy_cycles", busy_cnt, 4);
  endtask

  // --------------------------------------------------------------------------
  // Main stimulus
  // --------------------------------------------------------------------------
  logic [NB-1:0] va [NUM_B2B];
  logic [NB-1:0] vb [NUM_B2B];
  logic          vc [NUM_B2B];
  logic [NB:0]   ve [NUM_B2B];

  initial begin
    n_rst = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;

    // Test 1: reset state, visible before any clock edge
    #3;
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_sum", {16'd0, bus.sum}, 0);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 0);
    check("idle_done", {31'd0, bus.done}, 0);

    // Test 2: basic add
    do_op(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 1'b0);
    // Test 3: carry ripples across all chunks
    do_op(16'hFFFF, 16'h0000, 1'b1, sat_adj({1'b1, 16'h0000}), 1'b0);
    // Test 4: start during busy ignored
    do_op(16'h00F0, 16'h0010, 1'b0, {1'b0, 16'h0100}, 1'b1);
    repeat (8) @(negedge clk);

    // Test 5: reset in the second ADD cycle aborts the add
    @(negedge clk);
    bus.a = 16'h7777; bus.b = 16'h1111; bus.carry_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 0);
    check("abort_sum", {16'd0, bus.sum}, 0);
    check("abort_overflow", {31'd0, bus.overflow}, 0);
    last_sum = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.done) seen++;
      end
      check("no_done_after_abort", seen, 0);
    end
    do_op(16'h0FFF, 16'h0001, 1'b0, {1'b0, 16'h1000}, 1'b0);

    // Test 6: start held high, back-to-back adds every 5 cycles
    va[0] = 16'h0001; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = {1'b0, 16'h0002};
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; ve[1] = sat_adj({1'b1, 16'h0000});
    va[2] = 16'h7FFF; vb[2] = 16'h0000; vc[2] = 1'b1; ve[2] = {1'b0, 16'h8000};
    va[3] = 16'hABCD; vb[3] = 16'h1111; vc[3] = 1'b1; ve[3] = {1'b0, 16'hBCDF};
    for (int i = NUM_DIRECTED_B2B; i < NUM_B2B; i++) begin
      va[i] = NB'($urandom);
      vb[i] = NB'($urandom);
      vc[i] = 1'($urandom_range(1, 0));
      ve[i] = model(va[i], vb[i], vc[i]);
    end

    @(negedge clk);
    bus.a = va[0]; bus.b = vb[0]; bus.carry_in = vc[0]; bus.start = 1'b1;
    for (int i = 0; i < NUM_B2B; i++) begin
      @(posedge clk);
      push_exp(ve[i]);
      #1;
      if (i + 1 < NUM_B2B) begin
        bus.a = va[i+1]; bus.b = vb[i+1]; bus.carry_in = vc[i+1];
      end else begin
        bus.start = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      if (i < NUM_DIRECTED_B2B || i == NUM_B2B - 1) begin
        check("b2b_done_spacing", {31'd0, bus.done}, 1);
      end else if (!bus.done) begin
        checks++;
        errors++;
        $display("FAIL b2b_done_spacing actual=0 required=1 op=%0d t=%0t", i, $time);
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("completion_count", completions, pushes);
    $display("completed adds: %0d", completions);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
